fir_filter: RTL and testbench



---
 rtl/fir_filter_if.sv | 7 +
 rtl/fir_filter.sv | 37 +++
 tb/tb_fir_filter.sv | 101 ++++++++++
 3 files changed

// File: rtl/fir_filter_if.sv
// fir_filter_if: sample-in / filtered-sample-out stream for the FIR filter
interface fir_filter_if;
  logic signed [15:0] xn;
  logic signed [15:0] yn;
  modport master(output xn, input yn);
  modport slave(input xn, output yn);
endinterface

// File: rtl/fir_filter.sv
// fir_filter: fixed 11-tap symmetric Q1.15 low-pass FIR, one sample per clock
module fir_filter (
  input logic clk,
  input logic rst_n,
  fir_filter_if.slave bus
);
  localparam int TAPS = 11;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W = DATA_W + COEF_W + 4;
  localparam logic signed [COEF_W-1:0] h [TAPS] = '{
    -16'sd256, 16'sd0, 16'sd1024, 16'sd3072, 16'sd6144, 16'sd12800,
    16'sd6144, 16'sd3072, 16'sd1024, 16'sd0, -16'sd256
  };
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] r;
  logic signed [DATA_W-1:0] y_sat;
  // single-cycle multiply-accumulate, round-half-up and clamp to the sample range
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(x[k]) * ACC_W'(h[k]);
    r = (acc + ACC_W'(16384)) >>> 15;
    y_sat = r > ACC_W'(32767) ? 16'sh7fff : r < -ACC_W'(32768) ? 16'sh8000 : r[DATA_W-1:0];
  end
  // delay line shifts every clock; output registers the sum of the pre-shift window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '{default: '0};
      bus.yn <= '0;
    end else begin
      x[0] <= bus.xn;
      for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
      bus.yn <= y_sat;
    end
  end
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: random and directed stimulus checked against a convolution model
module tb_fir_filter;
  logic clk = 0;
  logic rst_n = 1;
  int compared = 0;
  int mismatched = 0;
  int coef [11] = '{-256, 0, 1024, 3072, 6144, 12800, 6144, 3072, 1024, 0, -256};
  int imp [11] = '{-256, 0, 1024, 3072, 6144, 12800, 6144, 3072, 1024, 0, -256};
  int seen [$];
  int expv = 0;
  fir_filter_if bus();
  fir_filter dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #10 clk = ~clk;
  // expected output after an edge: convolution of coefficients with the samples seen since reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen.delete();
      expv = 0;
    end else begin
      longint s;
      longint q;
      s = 0;
      for (int k = 0; k < 11 && k < seen.size(); k++) s += longint'(coef[k]) * seen[k];
      q = (s + 16384) >>> 15;
      expv = q > 32767 ? 32767 : q < -32768 ? -32768 : int'(q);
      seen.push_front(int'(bus.xn));
      if (seen.size() > 11) void'(seen.pop_back());
    end
  end
  // compare every cycle on the falling edge
  always @(negedge clk) begin
    compared++;
    if (int'(bus.yn) != expv) begin
      mismatched++;
      $display("FAIL model t=%0t yn=%0d expected=%0d", $time, bus.yn, expv);
    end
  end
  task automatic drive(input int v);
    @(negedge clk);
    #5 bus.xn = 16'(v);
  endtask
  task automatic lit(input string name, input int want);
    compared++;
    if (int'(bus.yn) != want) begin
      mismatched++;
      $display("FAIL %s t=%0t yn=%0d expected=%0d", name, $time, bus.yn, want);
    end
  endtask
  initial begin
    bus.xn = 16'sd12345;
    #1 rst_n = 0;
    repeat (4) begin
      @(negedge clk);
      #1 lit("reset_hold", 0);
    end
    #4 rst_n = 1;
    bus.xn = 0;
    repeat (5) drive(0);
    @(negedge clk);
    #1 lit("post_reset_zero", 0);
    drive(32767);
    @(negedge clk);
    #5 bus.xn = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      #1 lit($sformatf("impulse_%0d", i), imp[i]);
    end
    @(negedge clk);
    #1 lit("impulse_tail", 0);
    for (int i = 0; i < 14; i++) drive(16384);
    @(negedge clk);
    #1 lit("step_settled", 16384);
    repeat (12) drive(0);
    for (int k = 0; k < 11; k++) drive(coef[k] < 0 ? -32768 : 32767);
    drive(0);
    #1 lit("sat_pos", 32767);
    for (int k = 0; k < 11; k++) drive(coef[k] < 0 ? 32767 : -32768);
    drive(0);
    #1 lit("sat_neg", -32768);
    repeat (12) drive(0);
    drive(1);
    @(negedge clk);
    #5 bus.xn = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      #1 lit($sformatf("round_%0d", i), 0);
    end
    for (int n = 0; n < 256; n++) begin
      drive(int'($urandom_range(0, 65535)) - 32768);
      if (n == 100) begin
        #2 rst_n = 0;
        #1 lit("midstream_reset", 0);
        repeat (3) drive(int'($urandom_range(0, 65535)) - 32768);
        #3 rst_n = 1;
      end
    end
    repeat (14) drive(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
